// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, FIFO entry type and address helper for the fetch path
package fetch_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int PC_W = 32;
  localparam int WORD_BYTES = 4;
  localparam int DEPTH = 2;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;
  // ROM word index of a byte address; upper bits fall away so the ROM wraps
  function automatic logic [ADDR_W-1:0] word_addr(input logic [PC_W-1:0] a);
    return a[ADDR_W+1:2];
  endfunction
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry register FIFO of fetched words, head always registered
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t e0, e1, e0_n, e1_n;
  logic do_pop;
  logic [1:0] wr;
  assign do_pop = pop && count != 2'd0;
  assign wr = count - {1'b0, do_pop};
  assign head = e0;
  // shift on pop, then write the new word into the first free slot
  always_comb begin
    e0_n = (do_pop && count == 2'd2) ? e1 : e0;
    e1_n = e1;
    if (push && wr == 2'd0) e0_n = din;
    if (push && wr == 2'd1) e1_n = din;
  end
  // storage and occupancy; clear only empties, contents are don't-care afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      e0 <= '0;
      e1 <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      e0 <= e0_n;
      e1 <= e1_n;
      count <= count + {1'b0, push && wr != 2'd2} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing, ROM read issue, redirect and buffered decode handoff
module fetch_controller
  import fetch_pkg::*;
(
  input  logic              clka,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
);
  logic [PC_W-1:0] pc, inflight_pc, target;
  logic [ADDR_W-1:0] addr_q;
  logic inflight, pop, issue, push;
  logic [1:0] count;
  logic [2:0] load;
  fetch_entry_t head;
  assign target = branch_target & ~PC_W'(WORD_BYTES - 1);
  assign pop = inst_valid && inst_ready;
  assign load = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = fetch_en && !rst && (branch_taken || load < 3'(DEPTH));
  assign push = inflight && !branch_taken;
  // ROM address: redirect wins, otherwise the issuing PC, otherwise hold
  always_comb
    im_addr = rst ? word_addr(RESET_PC) : branch_taken ? word_addr(target) : issue ? word_addr(pc) : addr_q;
  // PC, in-flight tag and held address; a redirect squashes the arriving response
  always_ff @(posedge clka) begin
    if (rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      addr_q <= word_addr(RESET_PC);
    end else begin
      addr_q <= im_addr;
      inflight <= issue;
      if (issue) inflight_pc <= branch_taken ? target : pc;
      if (branch_taken) pc <= target + PC_W'(WORD_BYTES);
      else if (issue) pc <= pc + PC_W'(WORD_BYTES);
    end
  end
  fetch_skid_fifo u_fifo (
    .clk  (clka),
    .rst  (rst),
    .push (push),
    .din  ({im_data, inflight_pc}),
    .pop  (pop),
    .clear(branch_taken),
    .count(count),
    .head (head)
  );
  assign inst_valid = count != 2'd0;
  assign inst = head.inst;
  assign inst_pc = head.pc;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table plus scoreboard bench against a 1-cycle ROM model
module tb_fetch_controller;
  logic clka = 1'b0;
  logic rst = 1'b1;
  logic fetch_en = 1'b0;
  logic branch_taken = 1'b0;
  logic inst_ready = 1'b0;
  logic [31:0] branch_target = '0;
  logic [6:0] im_addr;
  logic [31:0] im_data, inst, inst_pc;
  logic inst_valid;
  int total = 0;
  int bad = 0;
  int delivered = 0;
  int d0;
  logic [31:0] sb[$];
  logic [31:0] hp;
  typedef struct {
    logic rst, en, rdy, v;
    logic [6:0] addr;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[8];

  fetch_controller dut (
    .clka(clka), .rst(rst), .fetch_en(fetch_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .im_addr(im_addr), .im_data(im_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clka = ~clka;
  always @(posedge clka) im_data <= 32'hA000_0000 | {25'd0, im_addr};

  function automatic logic [31:0] rom(input logic [31:0] pc);
    return 32'hA000_0000 | ((pc >> 2) & 32'h7F);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic load_sb(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic mon();
    if (!rst && inst_valid && inst_ready) begin
      delivered++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h want none", inst_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_inst", inst, rom(e));
      end
    end
  endtask

  task automatic tick();
    @(negedge clka);
    mon();
    @(posedge clka);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 32'd0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'd2, 32'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 32'd4};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'd4, 32'd8};
    load_sb(32'd0);
    @(posedge clka);
    #1;
    // reset and first stream cycles
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst;
      fetch_en = tbl[i].en;
      inst_ready = tbl[i].rdy;
      @(negedge clka);
      check("t_valid", 32'(inst_valid), 32'(tbl[i].v));
      check("t_addr", 32'(im_addr), 32'(tbl[i].addr));
      if (tbl[i].v) begin
        check("t_pc", inst_pc, tbl[i].pc);
        check("t_inst", inst, rom(tbl[i].pc));
      end
      mon();
      @(posedge clka);
      #1;
    end
    tick();
    // backpressure: head holds, no further reads issued
    inst_ready = 1'b0;
    hp = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clka);
      check("bp_valid", 32'(inst_valid), 32'd1);
      check("bp_pc", inst_pc, hp);
      check("bp_inst", inst, rom(hp));
      check("bp_addr", 32'(im_addr), ((hp >> 2) + 32'd1) & 32'h7F);
      @(posedge clka);
      #1;
    end
    inst_ready = 1'b1;
    repeat (4) tick();
    // redirect with a full FIFO
    inst_ready = 1'b0;
    repeat (2) tick();
    branch_taken = 1'b1;
    branch_target = 32'h40;
    @(negedge clka);
    check("r3_addr", 32'(im_addr), 32'h10);
    @(posedge clka);
    #1;
    branch_taken = 1'b0;
    inst_ready = 1'b1;
    load_sb(32'h40);
    @(negedge clka);
    check("r3_gap", 32'(inst_valid), 32'd0);
    @(posedge clka);
    #1;
    @(negedge clka);
    check("r3_valid", 32'(inst_valid), 32'd1);
    check("r3_pc", inst_pc, 32'h40);
    mon();
    @(posedge clka);
    #1;
    repeat (2) tick();
    // redirect coinciding with a pop, misaligned target
    branch_taken = 1'b1;
    branch_target = 32'h43;
    d0 = delivered;
    @(negedge clka);
    check("r4_addr", 32'(im_addr), 32'h10);
    mon();
    @(posedge clka);
    #1;
    check("r4_popped", 32'(delivered - d0), 32'd1);
    branch_taken = 1'b0;
    load_sb(32'h40);
    @(negedge clka);
    check("r4_gap", 32'(inst_valid), 32'd0);
    @(posedge clka);
    #1;
    @(negedge clka);
    check("r4_pc", inst_pc, 32'h40);
    mon();
    @(posedge clka);
    #1;
    repeat (2) tick();
    // wrap from ROM word 127 to word 0
    branch_taken = 1'b1;
    branch_target = 32'h1FC;
    tick();
    branch_taken = 1'b0;
    load_sb(32'h1FC);
    tick();
    @(negedge clka);
    check("w_inst0", inst, 32'hA000_007F);
    mon();
    @(posedge clka);
    #1;
    @(negedge clka);
    check("w_pc1", inst_pc, 32'h200);
    check("w_inst1", inst, 32'hA000_0000);
    mon();
    @(posedge clka);
    #1;
    repeat (2) tick();
    // fetch_en drops with one read in flight
    fetch_en = 1'b0;
    d0 = delivered;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("fe_idle", 32'(inst_valid), 32'd0);
      @(posedge clka);
      #1;
    end
    check("fe_count", 32'(delivered - d0), 32'd2);
    // resume, then reset mid-stream
    fetch_en = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clka);
    check("rs_addr", 32'(im_addr), 32'd0);
    @(posedge clka);
    #1;
    rst = 1'b0;
    load_sb(32'd0);
    @(negedge clka);
    check("rs_valid", 32'(inst_valid), 32'd0);
    check("rs_inst", inst, 32'd0);
    check("rs_pc", inst_pc, 32'd0);
    @(posedge clka);
    #1;
    tick();
    @(negedge clka);
    check("rs_restart", inst_pc, 32'd0);
    check("rs_rvalid", 32'(inst_valid), 32'd1);
    mon();
    @(posedge clka);
    #1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
